// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one active-low row at a time, debounces
// single-key presses and releases, and reports the accepted key code.
module keypad_scanner #(
    parameter int SCAN_DIV       = 5000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [3:0]    col_m, col_s;
    logic [DW-1:0] div;
    logic          tick;
    logic [1:0]    row_idx, row_idx_n;
    logic [3:0]    cand, cand_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [3:0]    code_n;
    logic          valid_n, held_n;
    logic          one_low, all_high, same_key;
    logic [1:0]    c_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_m <= '1;
            col_s <= '1;
            div   <= '0;
        end else begin
            col_m <= col;
            col_s <= col_m;
            div   <= (div == DIV_MAX) ? '0 : div + DW'(1);
        end
    end

    assign tick = (div == DIV_MAX);
    assign row  = ~(4'b0001 << row_idx);

    always_comb begin
        one_low = 1'b0;
        c_idx   = 2'd0;
        case (col_s)
            4'b1110: begin one_low = 1'b1; c_idx = 2'd0; end
            4'b1101: begin one_low = 1'b1; c_idx = 2'd1; end
            4'b1011: begin one_low = 1'b1; c_idx = 2'd2; end
            4'b0111: begin one_low = 1'b1; c_idx = 2'd3; end
            default: ;
        endcase
    end

    assign all_high = &col_s;
    assign same_key = one_low && (c_idx == cand[1:0]);
    assign cnt_inc  = cnt + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            row_idx   <= '0;
            cand      <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            row_idx   <= row_idx_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_held  <= held_n;
        end
    end

    // Press and release debounce share one counter; it is cleared on every exit.
    always_comb begin
        state_n   = state;
        row_idx_n = row_idx;
        cand_n    = cand;
        cnt_n     = cnt;
        code_n    = key_code;
        valid_n   = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (one_low) begin
                        cand_n = {row_idx, c_idx};
                        if (CNT_MAX == CNT_ONE) begin
                            code_n  = {row_idx, c_idx};
                            valid_n = 1'b1;
                            cnt_n   = '0;
                            state_n = HELD;
                        end else begin
                            cnt_n   = CNT_ONE;
                            state_n = DEBOUNCE;
                        end
                    end else begin
                        row_idx_n = row_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (same_key) begin
                        if (cnt_inc == CNT_MAX) begin
                            code_n  = cand;
                            valid_n = 1'b1;
                            cnt_n   = '0;
                            state_n = HELD;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        cnt_n     = '0;
                        row_idx_n = row_idx + 2'd1;
                        state_n   = SCAN;
                    end
                end
                HELD: begin
                    if (all_high) begin
                        if (CNT_MAX == CNT_ONE) begin
                            cnt_n     = '0;
                            row_idx_n = row_idx + 2'd1;
                            state_n   = SCAN;
                        end else begin
                            cnt_n   = CNT_ONE;
                            state_n = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (all_high) begin
                        if (cnt_inc == CNT_MAX) begin
                            cnt_n     = '0;
                            row_idx_n = row_idx + 2'd1;
                            state_n   = SCAN;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        cnt_n   = '0;
                        state_n = HELD;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
        held_n = (state_n == HELD) || (state_n == RELEASE);
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 5000: clk cycles each row stays driven; must be >= 2.
REQ-002 Parameter DEBOUNCE_SCANS, default 4: consecutive consistent samples needed to accept a press or a release; must be >= 1.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 col  input  4  keypad column lines, active-low (pulled up), asynchronous to clk.
REQ-006 row  output  4  keypad row drive, active-low, exactly one bit low at all times.
REQ-007 key_code  output  4  last accepted key, equal to row_index*4 + col_index.
REQ-008 key_valid  output  1  one-cycle pulse marking a newly accepted key.
REQ-009 key_held  output  1  high while an accepted key remains pressed.

Function
REQ-010 col SHALL pass through a 2-flop synchronizer; all sampling below uses the synchronized value (col_s).
REQ-011 Divider counts 0..SCAN_DIV-1 and wraps; "tick" = cycle where divider == SCAN_DIV-1.
REQ-012 row SHALL equal ~(4'b0001 << row_idx), with row_idx a 2-bit index.
REQ-013 row_idx advances only on a tick in state SCAN; 3 wraps to 0; frozen in DEBOUNCE, HELD and RELEASE.
REQ-014 States: SCAN, DEBOUNCE, HELD, RELEASE; decisions are taken on tick only; no state change between ticks.
REQ-015 SCAN, tick, col_s has exactly one low bit c: latch candidate = {row_idx, c}, set debounce count = 1, go to DEBOUNCE, and do not advance row_idx.
  - If DEBOUNCE_SCANS == 1, accept immediately per REQ-017.
REQ-016 SCAN, tick, col_s all high or two or more bits low: stay in SCAN and advance row_idx (multi-key presses are ignored).
REQ-017 DEBOUNCE, tick, col_s still shows the same single low bit: increment the count.
  - When the count reaches DEBOUNCE_SCANS: key_code <= candidate, key_valid = 1 for the next cycle only, go to HELD.
REQ-018 DEBOUNCE, tick, col_s differs from the candidate: discard the candidate, go to SCAN, advance row_idx, leave key_code unchanged.
REQ-019 HELD: key_held = 1.
  - Tick with col_s all high: go to RELEASE with release count = 1.
  - Otherwise stay in HELD.
REQ-020 RELEASE: key_held stays 1.
  - Tick with col_s all high: increment the release count; on reaching DEBOUNCE_SCANS go to SCAN, key_held = 0, advance row_idx.
  - Tick with any col_s bit low: return to HELD.
  - If DEBOUNCE_SCANS == 1, go to SCAN on the first all-high tick.
REQ-021 key_valid SHALL be registered, high for exactly one clk per accepted press; at most one pulse per press/release cycle, regardless of hold time.
REQ-022 key_code SHALL hold its value until the next accepted key; it never changes without a key_valid pulse in the same cycle.
REQ-023 Latency: key_valid rises 1 clk after the tick of the DEBOUNCE_SCANS-th consistent sample, i.e. (DEBOUNCE_SCANS-1)*SCAN_DIV+1 clk after the first detecting tick.
REQ-024 Column index c: bit 0 -> 0 ... bit 3 -> 3. Row index likewise (row[0] -> 0).

Reset
REQ-025 While rst_n = 0, all outputs and state SHALL be forced immediately, independent of clk:
  - row = 4'b1110, key_code = 4'h0, key_valid = 0, key_held = 0.
  - state = SCAN, row_idx = 0, divider = 0, counts = 0, synchronizer flops = 4'b1111.
REQ-026 Reset asserted mid-debounce or mid-hold SHALL discard the press; no key_valid pulse follows release of reset unless a new full debounce completes.
REQ-027 After rst_n rises, the first tick occurs SCAN_DIV clk later.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3)
REQ-028 Reset: drive rst_n=0 asynchronously mid-cycle -> outputs go to row=1110, key_code=0, key_valid=0, key_held=0 immediately; row then rotates 1110, 1101, 1011, 0111, 1110 every 4 clk with col=1111.
REQ-029 Single press: hold col=1011 (col 2) whenever row=1101 (row 1) -> row freezes at 1101; after 3 consistent ticks key_valid pulses once, key_code=4'h6, key_held=1.
REQ-030 Bounce: col low for 1 tick then high, in row 3 -> no key_valid, key_code unchanged, scan resumes at row 0.
REQ-031 Long hold then release: hold key 4'hF for 20 ticks -> exactly one key_valid; release -> key_held=0 after 3 all-high ticks; a glitch low during RELEASE returns to HELD with no new pulse.
REQ-032 Two keys in one row: col=1100 -> no detection and row keeps rotating; reset asserted during DEBOUNCE -> no pulse after reset release.
